// File: rtl/ddr5_mc_pkg.sv
// ddr5_mc_pkg: shared types and constants for the DDR5 controller.
// FSM state enum, CA opcodes, address-field layout, NOP CA value.
package ddr5_mc_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 30;
  localparam int CNT_W  = 16;

  localparam int COL_LSB = 0;
  localparam int COL_W   = 10;
  localparam int BA_LSB  = 10;
  localparam int BA_W    = 2;
  localparam int BG_LSB  = 12;
  localparam int BG_W    = 3;
  localparam int ROW_LSB = 15;
  localparam int ROW_W   = 15;

  localparam logic [4:0]  OP_WR  = 5'b01101;
  localparam logic [4:0]  OP_RD  = 5'b11101;
  localparam logic [4:0]  OP_PRE = 5'b11011;
  localparam logic [4:0]  OP_REF = 5'b10011;
  localparam logic [13:0] CA_NOP = 14'h3FFF;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_ACT,
    S_RCD_WAIT,
    S_CMD,
    S_LAT_WAIT,
    S_BURST,
    S_WR_RECOV,
    S_PRE,
    S_RP_WAIT,
    S_REF,
    S_RFC_WAIT
  } state_t;

endpackage

// File: rtl/ddr5_mem_controller_if.sv
// ddr5_mem_controller_if: request/response port of the controller.
// master = requester side, slave = controller side.
interface ddr5_mem_controller_if
  import ddr5_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int ADDR_WIDTH = AW_DEF
);
  logic                  in_valid;
  logic                  in_request_type;
  logic [ADDR_WIDTH-1:0] in_request_address;
  logic [DATA_WIDTH-1:0] in_request_data;
  logic                  out_busy;
  logic                  write_done;
  logic                  read_done;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output in_valid, in_request_type,
    output in_request_address, in_request_data,
    input  out_busy, write_done, read_done, data_out
  );

  modport slave (
    input  in_valid, in_request_type,
    input  in_request_address, in_request_data,
    output out_busy, write_done, read_done, data_out
  );
endinterface

// File: rtl/ddr5_mc_dq_phy.sv
// ddr5_mc_dq_phy: DQ/DQS tristate drive, DM_n, beat count, read capture.
// In: burst/wr/wdata from FSM. Out: last_beat, done pulses, data_out, pins.
module ddr5_mc_dq_phy
  import ddr5_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int BURST_LEN  = 16
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  burst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  last_beat,
  output logic                  write_done,
  output logic                  read_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            DM_n,
  inout  wire  [DATA_WIDTH-1:0] DQ,
  inout  wire  [2:0]            DQS_t,
  inout  wire  [2:0]            DQS_c
);
  localparam int BW = $clog2(BURST_LEN);

  logic [BW-1:0] beat;
  logic          drv;
  logic          first;

  assign first     = beat == '0;
  assign last_beat = burst && beat == BW'(BURST_LEN - 1);
  assign drv       = burst && wr;

  // only beat 0 carries the request word
  assign DQ    = drv ? (first ? wdata : '0) : 'z;
  assign DQS_t = drv ? {3{~beat[0]}} : 'z;
  assign DQS_c = drv ? {3{beat[0]}} : 'z;
  assign DM_n  = (drv && !first) ? 3'b100 : 3'b111;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat       <= '0;
      write_done <= 1'b0;
      read_done  <= 1'b0;
      data_out   <= '0;
    end else begin
      write_done <= drv && last_beat;
      read_done  <= 1'b0;
      beat       <= (burst && !last_beat) ? beat + 1'b1 : '0;
      if (burst && !wr && first) begin
        data_out  <= DQ;
        read_done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ddr5_mem_controller.sv
// ddr5_mem_controller: single-request in-order DDR5-style controller.
// Ports: clk, rst_n, bus (request port), CS_n/CA/CAI/DM_n/DQ/DQS, ALERT_n.
// Optional periodic REFab when MEMCTRL_REFRESH_EN is defined.
module ddr5_mem_controller
  import ddr5_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int ADDR_WIDTH = AW_DEF,
  parameter int T_INIT     = 64,
  parameter int T_RCD      = 8,
  parameter int T_CL       = 10,
  parameter int T_CWL      = 8,
  parameter int T_WR       = 8,
  parameter int T_RP       = 8,
`ifdef MEMCTRL_REFRESH_EN
  parameter int T_REFI     = 3900,
  parameter int T_RFC      = 64,
`endif
  parameter int BURST_LEN  = 16
)(
  input  logic                  clk,
  input  logic                  rst_n,
  ddr5_mem_controller_if.slave  bus,
  output logic                  CS_n,
  output logic [13:0]           CA,
  output logic                  CAI,
  output logic [2:0]            DM_n,
  inout  wire  [DATA_WIDTH-1:0] DQ,
  inout  wire  [2:0]            DQS_t,
  inout  wire  [2:0]            DQS_c,
  input  logic                  ALERT_n
);
  state_t                st, nst;
  logic [CNT_W-1:0]      cnt, ncnt;
  logic                  ph, nph;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  busy, accept, ref_go;
  logic                  last_beat;

  logic [ROW_W-1:0] row;
  logic [BG_W-1:0]  bg;
  logic [BA_W-1:0]  ba;
  logic [COL_W-1:0] col;

  assign row = r_addr[ROW_LSB +: ROW_W];
  assign bg  = r_addr[BG_LSB +: BG_W];
  assign ba  = r_addr[BA_LSB +: BA_W];
  assign col = r_addr[COL_LSB +: COL_W];

  assign busy   = !(st == S_IDLE && ALERT_n && !ref_go);
  assign accept = bus.in_valid && !busy;
  assign CAI    = 1'b0;
  assign bus.out_busy = busy;

`ifdef MEMCTRL_REFRESH_EN
  logic [CNT_W-1:0] refi;
  logic             ref_pend;
  logic             refi_hit;

  assign refi_hit = refi == CNT_W'(T_REFI - 1);
  assign ref_go   = ref_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refi     <= '0;
      ref_pend <= 1'b0;
    end else begin
      refi <= refi_hit ? '0 : refi + 1'b1;
      if (refi_hit)
        ref_pend <= 1'b1;
      else if (st == S_REF)
        ref_pend <= 1'b0;
    end
  end
`else
  assign ref_go = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= S_INIT;
      cnt    <= CNT_W'(T_INIT - 1);
      ph     <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      st  <= nst;
      cnt <= ncnt;
      ph  <= nph;
      if (accept) begin
        r_wr   <= bus.in_request_type;
        r_addr <= bus.in_request_address;
        r_data <= bus.in_request_data;
      end
    end
  end

  // wait states load N-2: the command's own last cycle counts as one
  always_comb begin
    nst  = st;
    ncnt = cnt;
    nph  = 1'b0;
    CS_n = 1'b1;
    CA   = CA_NOP;
    unique case (st)
      S_INIT:
        if (cnt == '0) nst = S_IDLE;
        else ncnt = cnt - 1'b1;
      S_IDLE:
        if (ref_go) nst = S_REF;
        else if (accept) nst = S_ACT;
      S_ACT:
        if (!ph) begin
          CS_n = 1'b0;
          CA   = {row[6:4], ba, bg, row[3:0], 2'b00};
          nph  = 1'b1;
        end else begin
          CA   = {6'h3F, row[14:7]};
          nst  = S_RCD_WAIT;
          ncnt = CNT_W'(T_RCD - 2);
        end
      S_RCD_WAIT:
        if (cnt == '0) nst = S_CMD;
        else ncnt = cnt - 1'b1;
      S_CMD:
        if (!ph) begin
          CS_n = 1'b0;
          CA   = {3'b111, bg, ba, 1'b1, r_wr ? OP_WR : OP_RD};
          nph  = 1'b1;
        end else begin
          CA   = {4'hF, col};
          nst  = S_LAT_WAIT;
          ncnt = r_wr ? CNT_W'(T_CWL - 2) : CNT_W'(T_CL - 2);
        end
      S_LAT_WAIT:
        if (cnt == '0) nst = S_BURST;
        else ncnt = cnt - 1'b1;
      S_BURST:
        if (last_beat) begin
          nst  = r_wr ? S_WR_RECOV : S_PRE;
          ncnt = CNT_W'(T_WR - 2);
        end
      S_WR_RECOV:
        if (cnt == '0) nst = S_PRE;
        else ncnt = cnt - 1'b1;
      S_PRE: begin
        CS_n = 1'b0;
        CA   = {3'b111, bg, ba, 1'b1, OP_PRE};
        nst  = S_RP_WAIT;
        ncnt = CNT_W'(T_RP - 2);
      end
      S_RP_WAIT:
        if (cnt == '0) nst = S_IDLE;
        else ncnt = cnt - 1'b1;
`ifdef MEMCTRL_REFRESH_EN
      S_REF: begin
        CS_n = 1'b0;
        CA   = {9'h1FF, OP_REF};
        nst  = S_RFC_WAIT;
        ncnt = CNT_W'(T_RFC - 1);
      end
      S_RFC_WAIT:
        if (cnt == '0) nst = S_IDLE;
        else ncnt = cnt - 1'b1;
`endif
      default: nst = S_INIT;
    endcase
  end

  ddr5_mc_dq_phy #(
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) u_phy (
    .clk        (clk),
    .rst_n      (rst_n),
    .burst      (st == S_BURST),
    .wr         (r_wr),
    .wdata      (r_data),
    .last_beat  (last_beat),
    .write_done (bus.write_done),
    .read_done  (bus.read_done),
    .data_out   (bus.data_out),
    .DM_n       (DM_n),
    .DQ         (DQ),
    .DQS_t      (DQS_t),
    .DQS_c      (DQS_c)
  );
endmodule

// File: tb/tb_ddr5_mem_controller.sv
// tb_ddr5_mem_controller: directed + randomized bench for ddr5_mem_controller.
// Expected CA/DQ/timing derived from the access timing rules and a memory map.
module tb_ddr5_mem_controller;
  localparam int T_INIT = 64;
  localparam int T_RCD  = 8;
  localparam int T_CL   = 10;
  localparam int T_CWL  = 8;
  localparam int T_WR   = 8;
  localparam int T_RP   = 8;
  localparam int BL     = 16;
  localparam logic [13:0] NOP = 14'h3FFF;

  logic clk = 1'b0;
  logic rst_n;
  logic alert_n;
  logic cs_n;
  logic cai;
  logic [13:0] ca;
  logic [2:0]  dm_n;
  wire  [15:0] dq;
  wire  [2:0]  dqs_t;
  wire  [2:0]  dqs_c;
  logic        tb_dq_en;
  logic [15:0] tb_dq;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] exp_dout;
  logic [15:0] mem [logic [29:0]];

  always #5 clk = ~clk;

  assign dq = tb_dq_en ? tb_dq : 'z;

  ddr5_mem_controller_if bus ();

  ddr5_mem_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .CS_n    (cs_n),
    .CA      (ca),
    .CAI     (cai),
    .DM_n    (dm_n),
    .DQ      (dq),
    .DQS_t   (dqs_t),
    .DQS_c   (dqs_c),
    .ALERT_n (alert_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [13:0] exp_ca(input int t, input int cmd1,
                                         input int pre, input bit wr,
                                         input logic [29:0] a);
    logic [14:0] row;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [9:0]  col;
    row = a[29:15];
    bg  = a[14:12];
    ba  = a[11:10];
    col = a[9:0];
    if (t == 1) return {row[6:4], ba, bg, row[3:0], 2'b00};
    if (t == 2) return {6'h3F, row[14:7]};
    if (t == cmd1)
      return {3'b111, bg, ba, 1'b1, wr ? 5'b01101 : 5'b11101};
    if (t == cmd1 + 1) return {4'hF, col};
    if (t == pre) return {3'b111, bg, ba, 1'b1, 5'b11011};
    return NOP;
  endfunction

  // call at the negedge after a reset posedge; releases reset
  task automatic init_check(input int ncyc);
    exp_dout = '0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      chk("init_busy", {31'd0, bus.out_busy}, {31'd0, n < T_INIT});
      chk("init_cs", {31'd0, cs_n}, 32'd1);
      chk("init_ca", {18'd0, ca}, {18'd0, NOP});
      chk("init_cai", {31'd0, cai}, 32'd0);
      chk("init_dm", {29'd0, dm_n}, 32'd7);
      chk("init_wdone", {31'd0, bus.write_done}, 32'd0);
      chk("init_rdone", {31'd0, bus.read_done}, 32'd0);
      chk("init_dout", {16'd0, bus.data_out}, {16'd0, exp_dout});
      rst_n = 1'b1;
    end
  endtask

  // call at a negedge with the DUT idle; returns at the negedge of
  // the first idle cycle (or right after asserting reset at abort_at)
  task automatic access(input bit wr, input logic [29:0] addr,
                        input logic [15:0] data, input int abort_at);
    int cmd1, b0, last, done, pre, idle;
    logic [15:0] rd;
    logic [2:0]  es;
    cmd1 = 2 + T_RCD;
    b0   = cmd1 + 1 + (wr ? T_CWL : T_CL);
    last = b0 + BL - 1;
    done = wr ? last + 1 : b0 + 1;
    pre  = wr ? last + T_WR : last + 1;
    idle = pre + T_RP;
    rd   = mem_rd(addr);
    chk("start_busy", {31'd0, bus.out_busy}, 32'd0);
    bus.in_valid           = 1'b1;
    bus.in_request_type    = wr;
    bus.in_request_address = addr;
    bus.in_request_data    = data;
    for (int t = 1; t <= idle; t++) begin
      @(negedge clk);
      if (!wr && t == done) exp_dout = rd;
      chk("cs_n", {31'd0, cs_n}, {31'd0, !(t == 1 || t == cmd1 || t == pre)});
      chk("ca", {18'd0, ca}, {18'd0, exp_ca(t, cmd1, pre, wr, addr)});
      chk("busy", {31'd0, bus.out_busy}, {31'd0, t < idle});
      chk("wdone", {31'd0, bus.write_done}, {31'd0, wr && t == done});
      chk("rdone", {31'd0, bus.read_done}, {31'd0, !wr && t == done});
      chk("dm_n", {29'd0, dm_n},
          (wr && t > b0 && t <= last) ? 32'd4 : 32'd7);
      chk("dout", {16'd0, bus.data_out}, {16'd0, exp_dout});
      if (wr && t >= b0 && t <= last) begin
        es = ((t - b0) % 2 == 0) ? 3'b111 : 3'b000;
        chk("dq_wr", {16'd0, dq}, (t == b0) ? {16'd0, data} : 32'd0);
        chk("dqs_t", {29'd0, dqs_t}, {29'd0, es});
        chk("dqs_c", {29'd0, dqs_c}, {29'd0, ~es});
      end
      if (wr && t == b0) mem[addr] = data;
      if (t == abort_at) begin
        rst_n        = 1'b0;
        tb_dq_en     = 1'b0;
        bus.in_valid = 1'b0;
        alert_n      = 1'b1;
        return;
      end
      bus.in_valid = (t < idle) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_request_type    = 1'($urandom_range(0, 1));
      bus.in_request_address = 30'($urandom);
      bus.in_request_data    = 16'($urandom);
      alert_n  = (t < idle - 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      tb_dq_en = !wr && t >= b0 && t <= last;
      tb_dq    = (t == b0) ? rd : 16'($urandom);
    end
  endtask

  initial begin
    bit          w;
    logic [29:0] a;
    logic [29:0] prev;
    logic [15:0] d;
    rst_n    = 1'b0;
    alert_n  = 1'b1;
    tb_dq_en = 1'b0;
    tb_dq    = '0;
    exp_dout = '0;
    bus.in_valid           = 1'b0;
    bus.in_request_type    = 1'b0;
    bus.in_request_address = '0;
    bus.in_request_data    = '0;
    repeat (3) @(posedge clk);
    init_check(100);

    access(1'b1, 30'd2, 16'd10, 0);
    access(1'b0, 30'd2, 16'd0, 0);
    access(1'b1, 30'h3FFF_FFFF, 16'hBEEF, 0);
    access(1'b0, 30'h3FFF_FFFF, 16'd0, 0);

    alert_n      = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("alert_busy", {31'd0, bus.out_busy}, 32'd1);
      chk("alert_cs", {31'd0, cs_n}, 32'd1);
    end
    alert_n      = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("alert_rel", {31'd0, bus.out_busy}, 32'd0);
    chk("alert_cs2", {31'd0, cs_n}, 32'd1);

    prev = 30'd2;
    for (int i = 0; i < 10; i++) begin
      w = 1'($urandom_range(0, 1));
      a = (i % 3 == 2) ? prev : 30'($urandom);
      d = 16'($urandom);
      access(w, a, d, 0);
      prev = a;
    end

    a = 30'($urandom);
    access(1'b1, a, 16'h1234, 2 + T_RCD + 1 + T_CWL + 3);
    init_check(T_INIT + 1);
    access(1'b0, 30'd2, 16'd0, 0);
    access(1'b0, a, 16'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
